// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state type and framing constants
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead receive FIFO with simultaneous push/pop at any occupancy
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot the same-cycle push needs, so full + pop still accepts.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with synchronizer, sampling FSM, FIFO and sticky errors
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          uartRxPin,
    input  logic                          rdEn,
    input  logic                          clrErr,
    output logic [7:0]                    rxData,
    output logic                          rxEmpty,
    output logic                          rxFull,
    output logic [$clog2(FIFO_DEPTH):0]   rxCount,
    output logic                          overrunErr,
    output logic                          frameErr,
    output logic                          rxBusy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic [1:0]           rst_q;
    logic                 rst_n;
    logic                 rx_meta;
    logic                 rx_s;
    logic [1:0]           warm_q;
    logic                 line_high;
    uart_state_t          state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 stop_tick;
    logic                 push;
    logic                 frame_evt;
    logic                 overrun_evt;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) rst_q <= 2'b00;
        else      rst_q <= {rst_q[0], 1'b1};
    end
    assign rst_n = rst_q[1];

    // warm_q marks when rx_s holds a real pin sample rather than its reset value.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            warm_q  <= 2'b00;
        end else begin
            rx_meta <= uartRxPin;
            rx_s    <= rx_meta;
            warm_q  <= {warm_q[0], 1'b1};
        end
    end

    // line_high arms start detection; cleared by a start or a low stop bit.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            line_high <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_high && !rx_s) begin
                        state     <= START;
                        cnt       <= '0;
                        bit_idx   <= '0;
                        line_high <= 1'b0;
                    end else if (warm_q[1] && rx_s) begin
                        line_high <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_TC) begin
                        cnt       <= '0;
                        state     <= rx_s ? IDLE : DATA;
                        line_high <= rx_s;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == FULL_TC) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + BW'(1);
                        if (bit_idx == LAST_BIT) state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == FULL_TC) begin
                        cnt       <= '0;
                        state     <= IDLE;
                        line_high <= rx_s;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stop_tick   = (state == STOP) && (cnt == FULL_TC);
    assign push        = stop_tick & rx_s;
    assign frame_evt   = stop_tick & ~rx_s;
    assign overrun_evt = push & rxFull & ~rdEn;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            overrunErr <= 1'b0;
            frameErr   <= 1'b0;
        end else begin
            overrunErr <= overrun_evt | (overrunErr & ~clrErr);
            frameErr   <= frame_evt   | (frameErr   & ~clrErr);
        end
    end

    assign rxBusy = (state != IDLE);

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (rst_n),
        .push  (push),
        .pop   (rdEn),
        .din   (shreg),
        .dout  (rxData),
        .count (rxCount),
        .full  (rxFull),
        .empty (rxEmpty)
    );

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - table-driven bench for uart_rx at 16 clocks per bit, 4-deep FIFO
module tb_uart_rx;

    localparam int CPB = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       uartRxPin = 1'b1;
    logic       rdEn = 1'b0;
    logic       clrErr = 1'b0;
    logic [7:0] rxData;
    logic       rxEmpty, rxFull, overrunErr, frameErr, rxBusy;
    logic [2:0] rxCount;

    int n_vec  = 0;
    int n_miss = 0;

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .uartRxPin  (uartRxPin),
        .rdEn       (rdEn),
        .clrErr     (clrErr),
        .rxData     (rxData),
        .rxEmpty    (rxEmpty),
        .rxFull     (rxFull),
        .rxCount    (rxCount),
        .overrunErr (overrunErr),
        .frameErr   (frameErr),
        .rxBusy     (rxBusy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_count;
        logic       exp_full;
        logic       exp_ovr;
        logic       exp_frm;
        logic [7:0] exp_head;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Start, 8 data bits LSB first, stop bit, then a short idle gap.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(negedge CLK);
        uartRxPin = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            uartRxPin = d[i];
            idle(CPB);
        end
        uartRxPin = stop;
        idle(CPB);
        uartRxPin = 1'b1;
        idle(8);
    endtask

    task automatic pop_one(input string name, input logic [7:0] exp);
        check(name, rxData, exp);
        rdEn = 1'b1;
        @(negedge CLK);
        rdEn = 1'b0;
    endtask

    task automatic pulse_clr();
        clrErr = 1'b1;
        @(negedge CLK);
        clrErr = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        logic seen_busy;

        tbl[0] = '{8'h3C, 1'b0, 0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[1] = '{8'h01, 1'b1, 1, 1'b0, 1'b0, 1'b1, 8'h01};
        tbl[2] = '{8'h02, 1'b1, 2, 1'b0, 1'b0, 1'b1, 8'h01};
        tbl[3] = '{8'h03, 1'b1, 3, 1'b0, 1'b0, 1'b1, 8'h01};
        tbl[4] = '{8'h04, 1'b1, 4, 1'b1, 1'b0, 1'b1, 8'h01};
        tbl[5] = '{8'h05, 1'b1, 4, 1'b1, 1'b1, 1'b1, 8'h01};

        idle(4);
        check("rst_empty", rxEmpty, 1);
        check("rst_full", rxFull, 0);
        check("rst_count", rxCount, 0);
        check("rst_ovr", overrunErr, 0);
        check("rst_frm", frameErr, 0);
        check("rst_busy", rxBusy, 0);
        check("rst_data", rxData, 0);
        RST = 1'b1;
        idle(20);

        // First frame: measure start-edge to rxEmpty latency.
        cyc = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(negedge CLK);
                while (rxEmpty && cyc < 300) begin
                    @(negedge CLK);
                    cyc++;
                end
            end
        join
        check_range("a5_latency", cyc, 154, 156);
        check("a5_data", rxData, 8'hA5);
        check("a5_count", rxCount, 1);
        check("a5_ovr", overrunErr, 0);
        check("a5_frm", frameErr, 0);
        pop_one("a5_pop", 8'hA5);
        check("a5_empty_after_pop", rxEmpty, 1);

        // Pop while empty is ignored.
        rdEn = 1'b1;
        @(negedge CLK);
        rdEn = 1'b0;
        @(negedge CLK);
        check("pop_empty_count", rxCount, 0);
        check("pop_empty_ovr", overrunErr, 0);

        // Short low pulse is rejected as a glitch.
        seen_busy = 1'b0;
        uartRxPin = 1'b0;
        idle(6);
        uartRxPin = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (rxBusy) seen_busy = 1'b1;
        end
        check("glitch_saw_busy", seen_busy, 1);
        check("glitch_busy", rxBusy, 0);
        check("glitch_empty", rxEmpty, 1);
        check("glitch_ovr", overrunErr, 0);
        check("glitch_frm", frameErr, 0);

        for (int v = 0; v < 6; v++) begin
            send_frame(tbl[v].data, tbl[v].stop);
            check($sformatf("vec%0d_count", v), rxCount, tbl[v].exp_count);
            check($sformatf("vec%0d_full", v), rxFull, tbl[v].exp_full);
            check($sformatf("vec%0d_ovr", v), overrunErr, tbl[v].exp_ovr);
            check($sformatf("vec%0d_frm", v), frameErr, tbl[v].exp_frm);
            if (tbl[v].exp_count > 0)
                check($sformatf("vec%0d_head", v), rxData, tbl[v].exp_head);
        end
        for (int i = 1; i <= 4; i++) begin
            pop_one($sformatf("fifo_order%0d", i), 8'(i));
        end
        check("drain_empty", rxEmpty, 1);
        pulse_clr();
        check("clr_ovr", overrunErr, 0);
        check("clr_frm", frameErr, 0);

        // Break: line held low yields one framing error and no bytes.
        uartRxPin = 1'b0;
        idle(500);
        check("break_frm", frameErr, 1);
        check("break_count", rxCount, 0);
        check("break_busy", rxBusy, 0);
        uartRxPin = 1'b1;
        idle(20);
        pulse_clr();

        // Full FIFO with a pop landing in the push cycle.
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h11 + 8'(i), 1'b1);
        end
        check("pp_prefull", rxFull, 1);
        fork
            send_frame(8'h55, 1'b1);
            begin
                @(negedge CLK);
                idle(154);
                rdEn = 1'b1;
                @(negedge CLK);
                rdEn = 1'b0;
            end
        join
        check("pp_count", rxCount, 4);
        check("pp_ovr", overrunErr, 0);
        check("pp_full", rxFull, 1);
        pop_one("pp_pop0", 8'h12);
        pop_one("pp_pop1", 8'h13);
        pop_one("pp_pop2", 8'h14);
        pop_one("pp_pop3", 8'h55);
        check("pp_empty", rxEmpty, 1);

        // Reset mid-frame abandons the byte and flushes the FIFO.
        send_frame(8'h42, 1'b1);
        check("mid_pre_count", rxCount, 1);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                @(negedge CLK);
                idle(5 * CPB + 4);
                RST = 1'b0;
                idle(1);
                check("mid_rst_count", rxCount, 0);
                check("mid_rst_busy", rxBusy, 0);
                idle(2);
                RST = 1'b1;
            end
        join
        idle(40);
        check("mid_after_count", rxCount, 0);
        check("mid_after_frm", frameErr, 0);

        // Line already low at reset release is not a start bit.
        uartRxPin = 1'b0;
        idle(2);
        RST = 1'b0;
        idle(3);
        RST = 1'b1;
        idle(60);
        check("low_release_busy", rxBusy, 0);
        uartRxPin = 1'b1;
        idle(20);
        check("low_release_count", rxCount, 0);
        check("low_release_frm", frameErr, 0);

        send_frame(8'h81, 1'b1);
        check("resume_count", rxCount, 1);
        check("resume_data", rxData, 8'h81);
        check("resume_frm", frameErr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
